// File: rtl/sdram_init_seq.sv
// SDRAM power-up / re-init command sequencer: PWR wait, PRECHARGE-all, N x AUTO-REFRESH, LOAD-MODE-REGISTER.
// Latency: all outputs registered; each command lasts one cycle, and gaps are NOP counted by a 16-bit down-counter.
// Backpressure: none. The sequence is self-timed, and init_req is honoured only in DONE.
module sdram_init_seq #(
    parameter int                PWR_WAIT  = 500,
    parameter int                T_RP      = 2,
    parameter int                T_RFC     = 7,
    parameter int                REF_COUNT = 2,
    parameter int                T_MRD     = 2,
    parameter int                ADDR_W    = 12,
    parameter logic [ADDR_W-1:0] MODE_REG  = ADDR_W'(12'h033)
) (
    input  logic              sdram_clk,
    input  logic              sdram_resetn,
    input  logic              init_req,
    output logic              sdr_cke,
    output logic              sdr_cs_n,
    output logic              sdr_ras_n,
    output logic              sdr_cas_n,
    output logic              sdr_we_n,
    output logic [1:0]        sdr_ba,
    output logic [ADDR_W-1:0] sdr_addr,
    output logic              sdr_init_done,
    output logic [2:0]        init_state
);

    typedef enum logic [2:0] {
        S_PWR  = 3'd0,
        S_PRE  = 3'd1,
        S_TRP  = 3'd2,
        S_AREF = 3'd3,
        S_TRFC = 3'd4,
        S_LMR  = 3'd5,
        S_TMRD = 3'd6,
        S_DONE = 3'd7
    } state_t;

    // {cs_n, ras_n, cas_n, we_n}
    localparam logic [3:0] CMD_NOP  = 4'b1111;
    localparam logic [3:0] CMD_PRE  = 4'b0010;
    localparam logic [3:0] CMD_AREF = 4'b0001;
    localparam logic [3:0] CMD_LMR  = 4'b0000;

    state_t            state, state_nxt;
    logic [15:0]       cnt, cnt_nxt;
    logic [3:0]        ref_cnt, ref_cnt_nxt;
    logic [3:0]        cmd_nxt;
    logic [ADDR_W-1:0] addr_nxt;
    logic              done_nxt;

    assign init_state = state;

    // Next-state, gap counter, refresh counter and next-cycle command pins.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        ref_cnt_nxt = ref_cnt;
        cmd_nxt     = CMD_NOP;
        addr_nxt    = '0;
        done_nxt    = 1'b0;

        case (state)
            // cke is still low on the first edge after reset release; that edge
            // only raises cke, so the NOP count starts at cycle 1.
            S_PWR:  if (sdr_cke && cnt == 16'd1) state_nxt = S_PRE;
            S_PRE:  state_nxt = S_TRP;
            S_TRP:  if (cnt == 16'd1) state_nxt = S_AREF;
            S_AREF: state_nxt = S_TRFC;
            S_TRFC: if (cnt == 16'd1)
                        state_nxt = (ref_cnt < 4'(REF_COUNT)) ? S_AREF : S_LMR;
            S_LMR:  state_nxt = S_TMRD;
            S_TMRD: if (cnt == 16'd1) state_nxt = S_DONE;
            S_DONE: if (init_req) state_nxt = S_PRE;
            default: state_nxt = S_PWR;
        endcase

        // Reload the gap length on every state change, otherwise count down to 1.
        if (state_nxt != state) begin
            case (state_nxt)
                S_TRP:   cnt_nxt = 16'(T_RP);
                S_TRFC:  cnt_nxt = 16'(T_RFC);
                S_TMRD:  cnt_nxt = 16'(T_MRD);
                default: cnt_nxt = 16'd1;
            endcase
        end else if (state == S_PWR && !sdr_cke) begin
            cnt_nxt = cnt;
        end else if (cnt > 16'd1) begin
            cnt_nxt = cnt - 16'd1;
        end

        // The refresh count restarts with every precharge so a re-init issues the full set.
        if (state_nxt == S_PRE)
            ref_cnt_nxt = 4'd0;
        else if (state == S_AREF)
            ref_cnt_nxt = ref_cnt + 4'd1;

        case (state_nxt)
            S_PRE: begin
                cmd_nxt      = CMD_PRE;
                addr_nxt[10] = 1'b1;
            end
            S_AREF: cmd_nxt = CMD_AREF;
            S_LMR: begin
                cmd_nxt  = CMD_LMR;
                addr_nxt = MODE_REG;
            end
            default: cmd_nxt = CMD_NOP;
        endcase
        done_nxt = (state_nxt == S_DONE);
    end

    // State, counters and registered SDRAM pins.
    always_ff @(posedge sdram_clk or negedge sdram_resetn) begin
        if (!sdram_resetn) begin
            state         <= S_PWR;
            cnt           <= 16'(PWR_WAIT);
            ref_cnt       <= 4'd0;
            sdr_cke       <= 1'b0;
            sdr_cs_n      <= 1'b1;
            sdr_ras_n     <= 1'b1;
            sdr_cas_n     <= 1'b1;
            sdr_we_n      <= 1'b1;
            sdr_ba        <= 2'b00;
            sdr_addr      <= '0;
            sdr_init_done <= 1'b0;
        end else begin
            state         <= state_nxt;
            cnt           <= cnt_nxt;
            ref_cnt       <= ref_cnt_nxt;
            sdr_cke       <= 1'b1;
            sdr_cs_n      <= cmd_nxt[3];
            sdr_ras_n     <= cmd_nxt[2];
            sdr_cas_n     <= cmd_nxt[1];
            sdr_we_n      <= cmd_nxt[0];
            sdr_ba        <= 2'b00;
            sdr_addr      <= addr_nxt;
            sdr_init_done <= done_nxt;
        end
    end

endmodule
